pe_mac_drain: RTL and testbench

Parametrised second-generation systolic processing element for the output-stationary MAC array. It keeps the registered east/south operand forwarding of the current PE, with these additions:
- per-operand valid qualifiers
- signed/unsigned mode
- configurable accumulator width with optional saturation and a sticky overflow flag
- a column drain chain that shifts finished results out without stopping the operand stream

---
 rtl/pe_mac_drain.sv | 158 +++++++++++++++
 tb/tb_pe_mac_drain.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_drain.sv
// ============================================================================
// Module   : pe_mac_drain
// Purpose  : Output-stationary systolic MAC processing element with operand
//            forwarding, optional saturation and a column drain chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_mac_drain #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid_out,
    input  logic              drain_start,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_valid_in,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid_out,
    output logic              overflow,
    output logic              draining
);

    typedef enum logic [0:0] {
        S_COMPUTE = 1'b0,
        S_DRAIN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic                a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic [ACC_W-1:0]    psum_q, psum_d;
    logic                psum_valid_q, psum_valid_d;
    logic                ovf_q, ovf_d;

    logic [2*DATA_W-1:0] w_a_wide, w_b_wide, w_prod;
    logic [ACC_W:0]      w_prod_ext, w_acc_ext, w_sum;
    logic [ACC_W-1:0]    w_acc_base, w_mac_res;
    logic                w_mac_en, w_capture, w_mac_ovf;

    // Extending both operands to the full product width makes the low half of
    // an unsigned multiply correct for signed and unsigned operands alike.
    assign w_a_wide = {{DATA_W{signed_mode & a_in[DATA_W-1]}}, a_in};
    assign w_b_wide = {{DATA_W{signed_mode & b_in[DATA_W-1]}}, b_in};
    assign w_prod   = w_a_wide * w_b_wide;

    assign w_mac_en   = a_valid_in & b_valid_in;
    assign w_capture  = (state_q == S_COMPUTE) & drain_start;
    // On a drain capture the new accumulation starts from zero in the same cycle.
    assign w_acc_base = w_capture ? '0 : acc_q;

    assign w_prod_ext = {{(ACC_W + 1 - 2*DATA_W){signed_mode & w_prod[2*DATA_W-1]}}, w_prod};
    assign w_acc_ext  = {signed_mode & w_acc_base[ACC_W-1], w_acc_base};
    assign w_sum      = w_acc_ext + w_prod_ext;

    assign w_mac_ovf = signed_mode ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];

    generate
        if (SATURATE != 0) begin : g_sat
            logic [ACC_W-1:0] w_limit;
            // Unsigned sums of products can only exceed the top; signed ones clamp by sign.
            assign w_limit   = !signed_mode  ? {ACC_W{1'b1}} :
                               w_sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                               {1'b0, {(ACC_W-1){1'b1}}};
            assign w_mac_res = w_mac_ovf ? w_limit : w_sum[ACC_W-1:0];
        end else begin : g_wrap
            assign w_mac_res = w_sum[ACC_W-1:0];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        psum_d       = psum_q;
        psum_valid_d = 1'b0;
        a_d          = a_in;
        a_valid_d    = a_valid_in;
        b_d          = b_in;
        b_valid_d    = b_valid_in;
        acc_d        = w_mac_en ? w_mac_res : w_acc_base;
        ovf_d        = ovf_q | (w_mac_en & w_mac_ovf);

        case (state_q)
            S_COMPUTE: begin
                if (drain_start) begin
                    psum_d       = acc_q;
                    psum_valid_d = 1'b1;
                    state_d      = S_DRAIN;
                end
            end
            S_DRAIN: begin
                psum_d       = psum_in;
                psum_valid_d = psum_valid_in;
                state_d      = psum_valid_in ? S_DRAIN : S_COMPUTE;
            end
            default: state_d = S_COMPUTE;
        endcase

        if (clear) begin
            state_d      = S_COMPUTE;
            psum_d       = '0;
            psum_valid_d = 1'b0;
            a_d          = '0;
            a_valid_d    = 1'b0;
            b_d          = '0;
            b_valid_d    = 1'b0;
            acc_d        = '0;
            ovf_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_COMPUTE;
            acc_q        <= '0;
            a_q          <= '0;
            a_valid_q    <= 1'b0;
            b_q          <= '0;
            b_valid_q    <= 1'b0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            a_q          <= a_d;
            a_valid_q    <= a_valid_d;
            b_q          <= b_d;
            b_valid_q    <= b_valid_d;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign a_out          = a_q;
    assign a_valid_out    = a_valid_q;
    assign b_out          = b_q;
    assign b_valid_out    = b_valid_q;
    assign psum_out       = psum_q;
    assign psum_valid_out = psum_valid_q;
    assign overflow       = ovf_q;
    assign draining       = (state_q == S_DRAIN);

endmodule

`default_nettype wire

// File: tb/tb_pe_mac_drain.sv
// ============================================================================
// Module   : tb_pe_mac_drain
// Purpose  : Directed self-checking bench for pe_mac_drain with drain scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pe_mac_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear, signed_mode, a_valid_in, b_valid_in, drain_start, p_vin;
    logic [7:0]  a_in, b_in;
    logic [23:0] p_in;

    logic [7:0]  m_a_out, m_b_out;
    logic        m_av, m_bv, m_pv, m_ovf, m_drn;
    logic [23:0] m_psum;

    logic [7:0]  s_a_out, s_b_out, w_a_out, w_b_out;
    logic        s_av, s_bv, s_pv, s_ovf, s_drn;
    logic        w_av, w_bv, w_pv, w_ovf, w_drn;
    logic [15:0] s_psum, w_psum;

    logic [7:0]  ca [3];
    logic [7:0]  cb;
    logic        cav, cbv, cds;
    logic [7:0]  ca_out [3];
    logic [7:0]  cb_out [3];
    logic        cav_out [3];
    logic        cbv_out [3];
    logic [23:0] cps [3];
    logic        cpv [3];
    logic        covf [3];
    logic        cdrn [3];

    int n_asserts = 0;
    int n_fail    = 0;
    logic [31:0] q_main [$];
    logic [31:0] q_chain [$];

    pe_mac_drain #(.DATA_W(8), .ACC_W(24), .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .signed_mode(signed_mode),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .a_out(m_a_out), .a_valid_out(m_av), .b_out(m_b_out), .b_valid_out(m_bv),
        .drain_start(drain_start), .psum_in(p_in), .psum_valid_in(p_vin),
        .psum_out(m_psum), .psum_valid_out(m_pv), .overflow(m_ovf), .draining(m_drn));

    pe_mac_drain #(.DATA_W(8), .ACC_W(16), .SATURATE(1)) u_s16 (
        .clk(clk), .rst(rst), .clear(clear), .signed_mode(signed_mode),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .a_out(s_a_out), .a_valid_out(s_av), .b_out(s_b_out), .b_valid_out(s_bv),
        .drain_start(drain_start), .psum_in(16'd0), .psum_valid_in(1'b0),
        .psum_out(s_psum), .psum_valid_out(s_pv), .overflow(s_ovf), .draining(s_drn));

    pe_mac_drain #(.DATA_W(8), .ACC_W(16), .SATURATE(0)) u_w16 (
        .clk(clk), .rst(rst), .clear(clear), .signed_mode(signed_mode),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .a_out(w_a_out), .a_valid_out(w_av), .b_out(w_b_out), .b_valid_out(w_bv),
        .drain_start(drain_start), .psum_in(16'd0), .psum_valid_in(1'b0),
        .psum_out(w_psum), .psum_valid_out(w_pv), .overflow(w_ovf), .draining(w_drn));

    pe_mac_drain #(.DATA_W(8), .ACC_W(24), .SATURATE(1)) u_c0 (
        .clk(clk), .rst(rst), .clear(1'b0), .signed_mode(1'b0),
        .a_in(ca[0]), .a_valid_in(cav), .b_in(cb), .b_valid_in(cbv),
        .a_out(ca_out[0]), .a_valid_out(cav_out[0]), .b_out(cb_out[0]), .b_valid_out(cbv_out[0]),
        .drain_start(cds), .psum_in(24'd0), .psum_valid_in(1'b0),
        .psum_out(cps[0]), .psum_valid_out(cpv[0]), .overflow(covf[0]), .draining(cdrn[0]));

    pe_mac_drain #(.DATA_W(8), .ACC_W(24), .SATURATE(1)) u_c1 (
        .clk(clk), .rst(rst), .clear(1'b0), .signed_mode(1'b0),
        .a_in(ca[1]), .a_valid_in(cav), .b_in(cb), .b_valid_in(cbv),
        .a_out(ca_out[1]), .a_valid_out(cav_out[1]), .b_out(cb_out[1]), .b_valid_out(cbv_out[1]),
        .drain_start(cds), .psum_in(cps[0]), .psum_valid_in(cpv[0]),
        .psum_out(cps[1]), .psum_valid_out(cpv[1]), .overflow(covf[1]), .draining(cdrn[1]));

    pe_mac_drain #(.DATA_W(8), .ACC_W(24), .SATURATE(1)) u_c2 (
        .clk(clk), .rst(rst), .clear(1'b0), .signed_mode(1'b0),
        .a_in(ca[2]), .a_valid_in(cav), .b_in(cb), .b_valid_in(cbv),
        .a_out(ca_out[2]), .a_valid_out(cav_out[2]), .b_out(cb_out[2]), .b_valid_out(cbv_out[2]),
        .drain_start(cds), .psum_in(cps[1]), .psum_valid_in(cpv[1]),
        .psum_out(cps[2]), .psum_valid_out(cpv[2]), .overflow(covf[2]), .draining(cdrn[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: each valid drain word is compared against the oldest expectation.
    always @(negedge clk) begin
        if (m_pv === 1'b1) begin
            if (q_main.size() == 0) check("main_unexpected_valid", {31'd0, m_pv}, 32'd0);
            else                    check("main_drain_word", {8'd0, m_psum}, q_main.pop_front());
        end
        if (cpv[2] === 1'b1) begin
            if (q_chain.size() == 0) check("chain_unexpected_valid", {31'd0, cpv[2]}, 32'd0);
            else                     check("chain_drain_word", {8'd0, cps[2]}, q_chain.pop_front());
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; signed_mode = 1'b0; drain_start = 1'b1;
        a_in = 8'hAA; a_valid_in = 1'b1; b_in = 8'h55; b_valid_in = 1'b1;
        p_in = 24'd0; p_vin = 1'b0;
        ca[0] = 8'd0; ca[1] = 8'd0; ca[2] = 8'd0; cb = 8'd0; cav = 1'b0; cbv = 1'b0; cds = 1'b0;
        tick(); tick();
        check("rst_a_out", {24'd0, m_a_out}, 32'd0);
        check("rst_a_valid_out", {31'd0, m_av}, 32'd0);
        check("rst_b_out", {24'd0, m_b_out}, 32'd0);
        check("rst_psum_valid", {31'd0, m_pv}, 32'd0);
        check("rst_psum_out", {8'd0, m_psum}, 32'd0);
        check("rst_overflow", {31'd0, m_ovf}, 32'd0);
        check("rst_draining", {31'd0, m_drn}, 32'd0);
        rst = 1'b0; drain_start = 1'b0;

        // Unsigned accumulation
        a_in = 8'd3;   b_in = 8'd4;   tick();
        a_in = 8'd10;  b_in = 8'd20;  tick();
        a_in = 8'd255; b_in = 8'd255; tick();
        check("fwd_a_out", {24'd0, m_a_out}, 32'd255);
        check("fwd_a_valid", {31'd0, m_av}, 32'd1);
        a_valid_in = 1'b0; b_valid_in = 1'b0;
        drain_start = 1'b1; q_main.push_back(32'd65237); tick();
        drain_start = 1'b0;
        check("unsigned_overflow", {31'd0, m_ovf}, 32'd0);
        check("drain_entered", {31'd0, m_drn}, 32'd1);
        tick();
        check("drain_left", {31'd0, m_drn}, 32'd0);
        check("single_valid_cycle", {31'd0, m_pv}, 32'd0);

        // Signed accumulation with a gated cycle
        signed_mode = 1'b1;
        a_in = 8'hFD; b_in = 8'h05; a_valid_in = 1'b1; b_valid_in = 1'b1; tick();
        check("fwd_a_neg", {24'd0, m_a_out}, 32'hFD);
        check("fwd_b_pos", {24'd0, m_b_out}, 32'h05);
        a_in = 8'd7; b_in = 8'd7; b_valid_in = 1'b0; tick();
        check("fwd_a_gated", {24'd0, m_a_out}, 32'd7);
        check("fwd_b_gated", {24'd0, m_b_out}, 32'd7);
        check("fwd_b_valid_low", {31'd0, m_bv}, 32'd0);
        check("fwd_a_valid_high", {31'd0, m_av}, 32'd1);
        a_in = 8'h80; b_in = 8'h80; b_valid_in = 1'b1; tick();
        a_valid_in = 1'b0; b_valid_in = 1'b0;
        drain_start = 1'b1; q_main.push_back(32'd16369); tick();
        drain_start = 1'b0; tick();
        check("signed_no_overflow", {31'd0, m_ovf}, 32'd0);

        // Saturation versus wrap at 16 bits
        signed_mode = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        a_in = 8'd255; b_in = 8'd255; a_valid_in = 1'b1; b_valid_in = 1'b1; tick(); tick();
        a_valid_in = 1'b0; b_valid_in = 1'b0;
        check("sat_overflow_set", {31'd0, s_ovf}, 32'd1);
        check("wrap_overflow_set", {31'd0, w_ovf}, 32'd1);
        check("wide_no_overflow", {31'd0, m_ovf}, 32'd0);
        drain_start = 1'b1; q_main.push_back(32'd130050); tick();
        drain_start = 1'b0;
        check("sat_clamp_value", {16'd0, s_psum}, 32'd65535);
        check("wrap_value", {16'd0, w_psum}, 32'd64514);
        check("sat_drain_valid", {31'd0, s_pv}, 32'd1);
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_sat_overflow", {31'd0, s_ovf}, 32'd0);
        check("clear_wrap_overflow", {31'd0, w_ovf}, 32'd0);
        check("clear_psum_out", {16'd0, s_psum}, 32'd0);
        drain_start = 1'b1; q_main.push_back(32'd0); tick();
        drain_start = 1'b0;
        check("clear_acc_valid", {31'd0, s_pv}, 32'd1);
        check("clear_acc_zero", {16'd0, s_psum}, 32'd0);
        tick();

        // Accumulation overlapping the drain
        a_in = 8'd1; b_in = 8'd9; a_valid_in = 1'b1; b_valid_in = 1'b1; tick();
        a_in = 8'd2; b_in = 8'd3; drain_start = 1'b1; q_main.push_back(32'd9); tick();
        drain_start = 1'b0; a_in = 8'd4; b_in = 8'd5; tick();
        a_valid_in = 1'b0; b_valid_in = 1'b0; tick();
        drain_start = 1'b1; q_main.push_back(32'd26); tick();
        drain_start = 1'b0; tick();

        // clear beats drain_start
        a_in = 8'd3; b_in = 8'd3; a_valid_in = 1'b1; b_valid_in = 1'b1; tick();
        a_valid_in = 1'b0; b_valid_in = 1'b0;
        clear = 1'b1; drain_start = 1'b1; tick();
        clear = 1'b0; drain_start = 1'b0;
        check("prio_no_valid", {31'd0, m_pv}, 32'd0);
        check("prio_no_drain", {31'd0, m_drn}, 32'd0);
        tick();
        drain_start = 1'b1; q_main.push_back(32'd0); tick();
        drain_start = 1'b0; tick();

        // rst during a multi-cycle drain
        p_in = 24'h123456; p_vin = 1'b1;
        a_in = 8'd2; b_in = 8'd2; a_valid_in = 1'b1; b_valid_in = 1'b1; tick();
        a_valid_in = 1'b0; b_valid_in = 1'b0;
        drain_start = 1'b1; q_main.push_back(32'd4); tick();
        drain_start = 1'b0; q_main.push_back(32'h123456); tick();
        check("drain_held_by_upstream", {31'd0, m_drn}, 32'd1);
        rst = 1'b1; tick();
        check("rst_mid_valid", {31'd0, m_pv}, 32'd0);
        check("rst_mid_psum", {8'd0, m_psum}, 32'd0);
        check("rst_mid_draining", {31'd0, m_drn}, 32'd0);
        check("rst_mid_a_out", {24'd0, m_a_out}, 32'd0);
        rst = 1'b0; p_vin = 1'b0; tick();

        // Three-deep drain chain
        ca[0] = 8'd5; ca[1] = 8'd6; ca[2] = 8'd7; cb = 8'd1; cav = 1'b1; cbv = 1'b1; tick();
        cav = 1'b0; cbv = 1'b0;
        cds = 1'b1; q_chain.push_back(32'd7); q_chain.push_back(32'd6); q_chain.push_back(32'd5); tick();
        cds = 1'b0;
        check("chain_top_draining", {31'd0, cdrn[0]}, 32'd1);
        check("chain_mid_draining", {31'd0, cdrn[1]}, 32'd1);
        check("chain_bot_draining", {31'd0, cdrn[2]}, 32'd1);
        tick();
        check("chain_top_released", {31'd0, cdrn[0]}, 32'd0);
        check("chain_mid_held", {31'd0, cdrn[1]}, 32'd1);
        tick();
        check("chain_mid_released", {31'd0, cdrn[1]}, 32'd0);
        check("chain_bot_held", {31'd0, cdrn[2]}, 32'd1);
        tick();
        check("chain_bot_released", {31'd0, cdrn[2]}, 32'd0);
        check("chain_bot_valid_low", {31'd0, cpv[2]}, 32'd0);
        tick(); tick();

        check("main_queue_drained", q_main.size(), 32'd0);
        check("chain_queue_drained", q_chain.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
